// File: rtl/universal_shift_pkg.sv
// Shared types and the single-step datapath function for universal_shift_reg_n.
// The step function works on a fixed maximum-width word so one definition
// serves every WIDTH; callers zero-extend Q in and truncate the result back.
package universal_shift_pkg;

  localparam int MAX_W = 64;

  typedef logic [MAX_W-1:0] word_t;

  typedef enum logic [2:0] {
    OP_HOLD = 3'd0,
    OP_LOAD = 3'd1,
    OP_SHL  = 3'd2,
    OP_SHR  = 3'd3,
    OP_ROL  = 3'd4,
    OP_ROR  = 3'd5,
    OP_INC  = 3'd6,
    OP_DEC  = 3'd7
  } op_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    word_t q;
    logic  out;
    logic  out_valid;
  } step_t;

  // Only shifts and rotates may be run as a multi-cycle burst.
  function automatic logic is_burst_op(op_t op);
    return (op == OP_SHL) || (op == OP_SHR) || (op == OP_ROL) || (op == OP_ROR);
  endfunction

  // One application of op to a width-bit value held in the low bits of q.
  // out/out_valid report the bit pushed out by a shift or rotate.
  function automatic step_t step(op_t op, word_t q, logic sin, word_t din,
                                 int unsigned width);
    step_t res;
    word_t mask;
    word_t msb_word;
    logic  msb;
    logic  lsb;
    mask      = (word_t'(1) << width) - word_t'(1);
    msb_word  = q >> (width - 1);
    msb       = msb_word[0];
    lsb       = q[0];
    res.q         = q;
    res.out       = 1'b0;
    res.out_valid = 1'b0;
    case (op)
      OP_LOAD: res.q = din & mask;
      OP_SHL: begin
        res.q         = ((q << 1) | word_t'(sin)) & mask;
        res.out       = msb;
        res.out_valid = 1'b1;
      end
      OP_SHR: begin
        res.q         = (q >> 1) | (word_t'(sin) << (width - 1));
        res.out       = lsb;
        res.out_valid = 1'b1;
      end
      OP_ROL: begin
        res.q         = ((q << 1) | word_t'(msb)) & mask;
        res.out       = msb;
        res.out_valid = 1'b1;
      end
      OP_ROR: begin
        res.q         = (q >> 1) | (word_t'(lsb) << (width - 1));
        res.out       = lsb;
        res.out_valid = 1'b1;
      end
      OP_INC:  res.q = (q + word_t'(1)) & mask;
      OP_DEC:  res.q = (q - word_t'(1)) & mask;
      default: res.q = q;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/universal_shift_reg_n.sv
// Parametrised universal register: single-cycle load/shift/rotate/inc/dec,
// plus a burst mode that repeats a shift or rotate a programmable number of
// times with a busy/done handshake. The burst controller is a two-state FSM;
// the register itself lives in a separate datapath process.
module universal_shift_reg_n
  import universal_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIN_W = 4,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic             start,
  input  logic [CNT_W-1:0] amount,
  input  logic             sin,
  input  logic [DIN_W-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             sout,
  output logic             busy,
  output logic             done,
  output logic             wrap
);

  localparam int unsigned WIDTH_U = WIDTH;

  op_t              op_in;
  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] remaining;
  logic [CNT_W-1:0] remaining_n;
  op_t              burst_op;
  op_t              burst_op_n;
  logic             done_n;
  logic             do_step;
  op_t              step_op;
  logic             wrap_n;
  step_t            step_res;

  assign op_in = op_t'(op);
  assign busy  = (state == RUN);

  // Burst controller state: current mode, steps still to do, latched op, done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      burst_op  <= OP_HOLD;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      burst_op  <= burst_op_n;
      done      <= done_n;
    end
  end

  // Decide next controller state and whether the datapath steps this edge, and with which op.
  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    burst_op_n  = burst_op;
    done_n      = 1'b0;
    do_step     = 1'b0;
    step_op     = op_in;
    if (en) begin
      case (state)
        IDLE: begin
          if (start && is_burst_op(op_in)) begin
            state_n     = RUN;
            remaining_n = amount;
            burst_op_n  = op_in;
          end else begin
            do_step = 1'b1;
            step_op = op_in;
          end
        end
        RUN: begin
          if (remaining != '0) begin
            do_step     = 1'b1;
            step_op     = burst_op;
            remaining_n = remaining - 1'b1;
          end else begin
            state_n = IDLE;
            done_n  = 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Compute the candidate next register value and the wrap condition for the selected op.
  always_comb begin
    step_res = step(step_op, word_t'(Q), sin, word_t'(D), WIDTH_U);
    wrap_n   = ((step_op == OP_INC) && (Q == '1)) ||
               ((step_op == OP_DEC) && (Q == '0));
  end

  if (WIDTH < MAX_W) begin : g_hi_bits
    logic unused_hi;
    assign unused_hi = ^step_res.q[MAX_W-1:WIDTH];
  end

  // Register, serial-out and wrap pulse; sout only moves when a bit is shifted or rotated out.
  always_ff @(posedge clk) begin
    if (rst) begin
      Q    <= '0;
      sout <= 1'b0;
      wrap <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (do_step) begin
        Q    <= step_res.q[WIDTH-1:0];
        wrap <= wrap_n;
        if (step_res.out_valid) begin
          sout <= step_res.out;
        end
      end
    end
  end

endmodule

// File: tb/tb_universal_shift_reg_n.sv
// Self-checking bench for universal_shift_reg_n (WIDTH=8, DIN_W=4):
// a directed vector table, two hand-written burst sequences, and a
// randomised run against an arithmetic reference model.
module tb_universal_shift_reg_n;

  localparam int WIDTH = 8;
  localparam int DIN_W = 4;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int MOD   = 1 << WIDTH;
  localparam int HALF  = MOD / 2;

  localparam logic [2:0] HOLD = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] SHL  = 3'd2;
  localparam logic [2:0] SHR  = 3'd3;
  localparam logic [2:0] ROL  = 3'd4;
  localparam logic [2:0] ROR  = 3'd5;
  localparam logic [2:0] INC  = 3'd6;
  localparam logic [2:0] DEC  = 3'd7;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [2:0]       op;
  logic             start;
  logic [CNT_W-1:0] amount;
  logic             sin;
  logic [DIN_W-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             sout;
  logic             busy;
  logic             done;
  logic             wrap;

  int errors = 0;
  int checks = 0;

  int m_q, m_sout, m_busy, m_done, m_wrap, m_rem, m_op;

  typedef struct {
    logic             rst;
    logic             en;
    logic [2:0]       op;
    logic             start;
    logic [CNT_W-1:0] amount;
    logic             sin;
    logic [DIN_W-1:0] d;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic             wrap;
    logic             sout;
  } vec_t;

  vec_t vecs[18];

  universal_shift_reg_n #(.WIDTH(WIDTH), .DIN_W(DIN_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .en(en), .op(op), .start(start), .amount(amount),
    .sin(sin), .D(D), .Q(Q), .sout(sout), .busy(busy), .done(done), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs, then let the edge happen and settle.
  task automatic applyStimulus(input logic r, input logic e, input logic [2:0] o,
                               input logic s, input logic [CNT_W-1:0] a,
                               input logic si, input logic [DIN_W-1:0] d);
    rst = r; en = e; op = o; start = s; amount = a; sin = si; D = d;
    @(posedge clk);
    #1;
  endtask

  task automatic checkVal(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic checkOutput(input string name, input logic [WIDTH-1:0] eq,
                             input logic eb, input logic ed, input logic ew,
                             input logic es);
    checkVal({name, ".q"},    int'(Q),    int'(eq));
    checkVal({name, ".busy"}, int'(busy), int'(eb));
    checkVal({name, ".done"}, int'(done), int'(ed));
    checkVal({name, ".wrap"}, int'(wrap), int'(ew));
    checkVal({name, ".sout"}, int'(sout), int'(es));
  endtask

  // Reference: one operation on the model register using plain arithmetic.
  task automatic modelApply(input int o, input int si, input int d);
    case (o)
      1: m_q = d;
      2: begin m_sout = m_q / HALF; m_q = (m_q * 2) % MOD + si; end
      3: begin m_sout = m_q % 2;    m_q = m_q / 2 + si * HALF; end
      4: begin m_sout = m_q / HALF; m_q = (m_q * 2) % MOD + m_q / HALF; end
      5: begin m_sout = m_q % 2;    m_q = m_q / 2 + (m_q % 2) * HALF; end
      6: begin m_wrap = (m_q == MOD - 1) ? 1 : 0; m_q = (m_q + 1) % MOD; end
      7: begin m_wrap = (m_q == 0) ? 1 : 0;       m_q = (m_q + MOD - 1) % MOD; end
      default: ;
    endcase
  endtask

  // Reference: behaviour of one clock edge given that cycle's inputs.
  task automatic modelStep(input int r, input int e, input int o, input int s,
                           input int a, input int si, input int d);
    if (r != 0) begin
      m_q = 0; m_sout = 0; m_busy = 0; m_done = 0; m_wrap = 0; m_rem = 0; m_op = 0;
    end else begin
      m_done = 0;
      m_wrap = 0;
      if (e != 0) begin
        if (m_busy == 0) begin
          if (s != 0 && o >= 2 && o <= 5) begin
            m_busy = 1; m_op = o; m_rem = a;
          end else begin
            modelApply(o, si, d);
          end
        end else if (m_rem > 0) begin
          modelApply(m_op, si, d);
          m_rem--;
        end else begin
          m_busy = 0;
          m_done = 1;
        end
      end
    end
  endtask

  initial begin
    int busy_cycles;
    int guard;
    logic r, e, s, si;
    logic [2:0] o;
    logic [CNT_W-1:0] a;
    logic [DIN_W-1:0] d;

    // rst en op start amt sin d | q busy done wrap sout
    vecs[0]  = '{1'b1, 1'b1, SHL,  1'b1, 4'd3, 1'b1, 4'hF, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, INC,  1'b0, 4'd7, 1'b1, 4'hA, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, LOAD, 1'b0, 4'd0, 1'b0, 4'hB, 8'h0B, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, LOAD, 1'b0, 4'd0, 1'b0, 4'hF, 8'h0B, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, SHR,  1'b1, 4'd2, 1'b0, 4'h0, 8'h0B, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, HOLD, 1'b0, 4'd0, 1'b0, 4'h0, 8'h05, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 1'b1, HOLD, 1'b0, 4'd0, 1'b0, 4'h0, 8'h02, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, HOLD, 1'b0, 4'd0, 1'b0, 4'h0, 8'h02, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b1, HOLD, 1'b0, 4'd0, 1'b0, 4'h0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, LOAD, 1'b0, 4'd0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b1, DEC,  1'b0, 4'd0, 1'b0, 4'h0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 1'b1, INC,  1'b0, 4'd0, 1'b0, 4'h0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 1'b1, INC,  1'b0, 4'd0, 1'b0, 4'h0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b1, INC,  1'b1, 4'd3, 1'b0, 4'h0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[14] = '{1'b0, 1'b1, HOLD, 1'b0, 4'd0, 1'b0, 4'h0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[15] = '{1'b0, 1'b1, SHL,  1'b1, 4'd0, 1'b0, 4'h0, 8'h02, 1'b1, 1'b0, 1'b0, 1'b1};
    vecs[16] = '{1'b0, 1'b1, HOLD, 1'b0, 4'd0, 1'b0, 4'h0, 8'h02, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 1'b1, HOLD, 1'b0, 4'd0, 1'b0, 4'h0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b1};

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].en, vecs[i].op, vecs[i].start,
                    vecs[i].amount, vecs[i].sin, vecs[i].d);
      checkOutput($sformatf("vec%0d", i), vecs[i].q, vecs[i].busy, vecs[i].done,
                  vecs[i].wrap, vecs[i].sout);
    end

    // ROR by 4 with a two-cycle stall and a stray SHL start while busy.
    applyStimulus(1'b1, 1'b1, HOLD, 1'b0, 4'd0, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b1, LOAD, 1'b0, 4'd0, 1'b0, 4'hB);
    checkOutput("ror_load", 8'h0B, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, ROR, 1'b1, 4'd4, 1'b0, 4'h0);
    checkOutput("ror_start", 8'h0B, 1'b1, 1'b0, 1'b0, 1'b0);
    busy_cycles = 1;
    applyStimulus(1'b0, 1'b1, SHL, 1'b1, 4'd7, 1'b1, 4'h0);
    checkOutput("ror_step1", 8'h85, 1'b1, 1'b0, 1'b0, 1'b1);
    busy_cycles++;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 1'b0, SHL, 1'b1, 4'd7, 1'b1, 4'h0);
      checkOutput($sformatf("ror_stall%0d", i), 8'h85, 1'b1, 1'b0, 1'b0, 1'b1);
      busy_cycles++;
    end
    guard = 0;
    while (busy && guard < 20) begin
      applyStimulus(1'b0, 1'b1, SHL, 1'b1, 4'd7, 1'b1, 4'h0);
      if (busy) busy_cycles++;
      guard++;
    end
    checkVal("ror_busy_cycles", busy_cycles, 7);
    checkOutput("ror_done", 8'hB0, 1'b0, 1'b1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, HOLD, 1'b0, 4'd0, 1'b0, 4'h0);
    checkOutput("ror_after", 8'hB0, 1'b0, 1'b0, 1'b0, 1'b1);

    // ROL by 5 aborted by reset after two steps.
    applyStimulus(1'b1, 1'b1, HOLD, 1'b0, 4'd0, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b1, LOAD, 1'b0, 4'd0, 1'b0, 4'hB);
    applyStimulus(1'b0, 1'b1, ROL, 1'b1, 4'd5, 1'b0, 4'h0);
    checkOutput("rol_start", 8'h0B, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, HOLD, 1'b0, 4'd0, 1'b0, 4'h0);
    checkOutput("rol_step1", 8'h16, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, HOLD, 1'b0, 4'd0, 1'b0, 4'h0);
    checkOutput("rol_step2", 8'h2C, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b1, INC, 1'b1, 4'd3, 1'b1, 4'h7);
    checkOutput("rol_reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, HOLD, 1'b0, 4'd0, 1'b0, 4'h0);
    checkOutput("rol_nodone", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, LOAD, 1'b0, 4'd0, 1'b0, 4'h3);
    checkOutput("rol_reload", 8'h03, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomised run against the reference model.
    modelStep(1, 1, 0, 0, 0, 0, 0);
    applyStimulus(1'b1, 1'b1, HOLD, 1'b0, 4'd0, 1'b0, 4'h0);
    for (int i = 0; i < 400; i++) begin
      r  = ($urandom_range(0, 39) == 0);
      e  = ($urandom_range(0, 4) != 0);
      o  = 3'($urandom_range(0, 7));
      s  = ($urandom_range(0, 3) == 0);
      a  = CNT_W'($urandom_range(0, (1 << CNT_W) - 1));
      si = 1'($urandom_range(0, 1));
      d  = DIN_W'($urandom_range(0, (1 << DIN_W) - 1));
      modelStep(int'(r), int'(e), int'(o), int'(s), int'(a), int'(si), int'(d));
      applyStimulus(r, e, o, s, a, si, d);
      checkOutput($sformatf("rand%0d", i), WIDTH'(m_q), 1'(m_busy), 1'(m_done),
                  1'(m_wrap), 1'(m_sout));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
